// File: rtl/rf_debug_port.sv
// Debug-host master for the core register file: single read/write and full dump.
// Optional dump sequence is built only when RF_DEBUG_DUMP_EN is defined.
module rf_debug_port #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_halted,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [AW-1:0] rsp_addr,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          rsp_err,
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_rd,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic          rf_we,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RSP
`ifdef RF_DEBUG_DUMP_EN
    , S_DUMP_RD,
    S_DUMP_RSP
`endif
  } state_t;

  state_t        r_state, w_state;
  logic          r_rsp_valid, w_rsp_valid;
  logic [AW-1:0] r_rsp_addr, w_rsp_addr;
  logic [DW-1:0] r_rsp_data, w_rsp_data;
  logic          r_rsp_last, w_rsp_last;
  logic          r_rsp_err, w_rsp_err;
  logic [AW-1:0] r_rf_ra, w_rf_ra;
  logic [AW-1:0] r_rf_wa, w_rf_wa;
  logic [DW-1:0] r_rf_wd, w_rf_wd;
  logic          r_rf_we, w_rf_we;
  logic [AW-1:0] r_addr, w_addr;
  logic          w_accept;
`ifdef RF_DEBUG_DUMP_EN
  logic [AW-1:0] r_cnt, w_cnt;
`endif

  assign cmd_ready = (r_state == S_IDLE) && core_halted && !reset;
  assign w_accept  = cmd_valid && cmd_ready;

  always_comb begin
    w_state     = r_state;
    w_rsp_valid = r_rsp_valid;
    w_rsp_addr  = r_rsp_addr;
    w_rsp_data  = r_rsp_data;
    w_rsp_last  = r_rsp_last;
    w_rsp_err   = r_rsp_err;
    w_rf_ra     = r_rf_ra;
    w_rf_wa     = r_rf_wa;
    w_rf_wd     = r_rf_wd;
    w_rf_we     = 1'b0;
    w_addr      = r_addr;
`ifdef RF_DEBUG_DUMP_EN
    w_cnt       = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            2'b00: begin
              w_rf_ra = cmd_addr;
              w_addr  = cmd_addr;
              w_state = S_RD;
            end
            2'b01: begin
              // x0 is hardwired to zero, so the write strobe is suppressed for it
              w_rf_wa = cmd_addr;
              w_rf_wd = cmd_wdata;
              w_rf_we = (cmd_addr != '0);
              w_addr  = cmd_addr;
              w_state = S_WR;
            end
`ifdef RF_DEBUG_DUMP_EN
            2'b10: begin
              w_cnt   = '0;
              w_rf_ra = '0;
              w_state = S_DUMP_RD;
            end
`endif
            default: begin
              w_rsp_valid = 1'b1;
              w_rsp_err   = 1'b1;
              w_rsp_data  = '0;
              w_rsp_last  = 1'b1;
              w_rsp_addr  = cmd_addr;
              w_state     = S_RSP;
            end
          endcase
        end
      end
      S_RD: begin
        w_rsp_valid = 1'b1;
        w_rsp_data  = rf_rd;
        w_rsp_addr  = r_addr;
        w_rsp_last  = 1'b1;
        w_rsp_err   = 1'b0;
        w_state     = S_RSP;
      end
      S_WR: begin
        w_rsp_valid = 1'b1;
        w_rsp_data  = r_rf_wd;
        w_rsp_addr  = r_addr;
        w_rsp_last  = 1'b1;
        w_rsp_err   = 1'b0;
        w_state     = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state     = S_IDLE;
        end
      end
`ifdef RF_DEBUG_DUMP_EN
      S_DUMP_RD: begin
        w_rsp_valid = 1'b1;
        w_rsp_data  = rf_rd;
        w_rsp_addr  = r_cnt;
        w_rsp_last  = (r_cnt == AW'(NREGS - 1));
        w_rsp_err   = 1'b0;
        w_state     = S_DUMP_RSP;
      end
      S_DUMP_RSP: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          if (r_rsp_last) begin
            w_state = S_IDLE;
          end else begin
            w_cnt   = r_cnt + 1'b1;
            w_rf_ra = r_cnt + 1'b1;
            w_state = S_DUMP_RD;
          end
        end
      end
`endif
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rf_ra     <= '0;
      r_rf_wa     <= '0;
      r_rf_wd     <= '0;
      r_rf_we     <= 1'b0;
      r_addr      <= '0;
`ifdef RF_DEBUG_DUMP_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_state     <= w_state;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_addr  <= w_rsp_addr;
      r_rsp_data  <= w_rsp_data;
      r_rsp_last  <= w_rsp_last;
      r_rsp_err   <= w_rsp_err;
      r_rf_ra     <= w_rf_ra;
      r_rf_wa     <= w_rf_wa;
      r_rf_wd     <= w_rf_wd;
      r_rf_we     <= w_rf_we;
      r_addr      <= w_addr;
`ifdef RF_DEBUG_DUMP_EN
      r_cnt       <= w_cnt;
`endif
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_data  = r_rsp_data;
  assign rsp_last  = r_rsp_last;
  assign rsp_err   = r_rsp_err;
  assign rf_ra     = r_rf_ra;
  assign rf_wa     = r_rf_wa;
  assign rf_wd     = r_rf_wd;
  assign rf_we     = r_rf_we;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_rf_debug_port.sv
// Self-checking bench for rf_debug_port: regfile stub plus a shadow register model.
module tb_rf_debug_port;

  logic        clk, reset, core_halted;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_last, rsp_err;
  logic [4:0]  rf_ra, rf_wa;
  logic [31:0] rf_rd, rf_wd;
  logic        rf_we, busy;

  logic [31:0] rf_mem [32];
  logic [31:0] ref_regs [32];
  int          vectors = 0;
  int          miscompares = 0;
  int          we_cnt = 0;
  logic [4:0]  we_wa;
  logic [31:0] we_wd;

  rf_debug_port dut (
    .clk(clk), .reset(reset), .core_halted(core_halted),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .rf_we(rf_we), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile stub: x0 reads zero, writes commit on the falling edge
  assign rf_rd = (rf_ra == 5'd0) ? 32'd0 : rf_mem[rf_ra];
  always @(negedge clk) begin
    if (rf_we) begin
      we_cnt = we_cnt + 1;
      we_wa  = rf_wa;
      we_wd  = rf_wd;
      if (rf_wa != 5'd0) rf_mem[rf_wa] = rf_wd;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end

  task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d,
                       output bit ok);
    int n = 0;
    ok = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      vectors++; miscompares++;
      $display("FAIL cmd_ready_timeout: cmd_ready=%0b required 1", cmd_ready);
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    ok = 1;
  endtask

  task automatic get_rsp(input int stall, output logic [4:0] a, output logic [31:0] d,
                         output logic l, output logic e, output bit ok);
    int n = 0;
    ok = 0; a = '0; d = '0; l = 1'b0; e = 1'b0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      vectors++; miscompares++;
      $display("FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid);
      return;
    end
    a = rsp_addr; d = rsp_data; l = rsp_last; e = rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err} !== {1'b1, a, d, l, e}) begin
        miscompares++;
        $display("FAIL rsp_hold: got %h required %h",
                 {rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err}, {1'b1, a, d, l, e});
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    ok = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err,
         rf_ra, rf_wa, rf_wd, rf_we, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got nonzero (valid=%0b we=%0b busy=%0b ra=%0d) required all 0",
               rsp_valid, rf_we, busy, rf_ra);
    end
    reset = 1'b0;
    core_halted = 1'b1;
    @(negedge clk);
    vectors++;
    if ({cmd_ready, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_idle: ready/busy=%b required 10", {cmd_ready, busy});
    end
  endtask

  task automatic test_write_read();
    bit ok; logic [4:0] a; logic [31:0] d; logic l, e;
    we_cnt = 0;
    issue(2'b01, 5'd9, 32'hDEADBEEF, ok);
    get_rsp(1, a, d, l, e, ok);
    if (ok) begin
      ref_regs[9] = 32'hDEADBEEF;
      vectors++;
      if ({a, d, l, e} !== {5'd9, 32'hDEADBEEF, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL write9_rsp: got %h required %h", {a, d, l, e}, {5'd9, 32'hDEADBEEF, 2'b10});
      end
    end
    vectors++;
    if (we_cnt !== 1 || we_wa !== 5'd9 || we_wd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL write9_we: we_cycles=%0d wa=%0d wd=%h required 1 cycle, 9, deadbeef",
               we_cnt, we_wa, we_wd);
    end
    issue(2'b00, 5'd9, 32'd0, ok);
    @(negedge clk);
    vectors++;
    if ({rsp_valid, busy, rf_ra} !== {1'b0, 1'b1, 5'd9}) begin
      miscompares++;
      $display("FAIL read9_latency: valid/busy/ra=%b required 0/1/01001", {rsp_valid, busy, rf_ra});
    end
    get_rsp(0, a, d, l, e, ok);
    vectors++;
    if ({a, d, l, e} !== {5'd9, ref_regs[9], 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL read9_rsp: got %h required %h", {a, d, l, e}, {5'd9, ref_regs[9], 2'b10});
    end
  endtask

  task automatic test_x0_write();
    bit ok; logic [4:0] a; logic [31:0] d; logic l, e;
    we_cnt = 0;
    issue(2'b01, 5'd0, 32'h12345678, ok);
    get_rsp(0, a, d, l, e, ok);
    vectors++;
    if ({a, d, l, e} !== {5'd0, 32'h12345678, 1'b1, 1'b0} || we_cnt !== 0) begin
      miscompares++;
      $display("FAIL x0_write: rsp=%h we_cycles=%0d required %h and 0",
               {a, d, l, e}, we_cnt, {5'd0, 32'h12345678, 2'b10});
    end
    issue(2'b00, 5'd0, 32'd0, ok);
    get_rsp(0, a, d, l, e, ok);
    vectors++;
    if (d !== 32'd0 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_read: data=%h err=%0b required 0 0", d, e);
    end
  endtask

  task automatic test_random_ops();
    bit ok; logic [4:0] a, ra; logic [31:0] d, rd; logic l, e, op;
    logic [31:0] exp_d;
    for (int i = 0; i < 30; i++) begin
      op = 1'($urandom_range(0, 1));
      ra = 5'($urandom_range(0, 31));
      rd = $urandom;
      we_cnt = 0;
      issue({1'b0, op}, ra, rd, ok);
      get_rsp($urandom_range(0, 2), a, d, l, e, ok);
      if (op) begin
        exp_d = rd;
        if (ra != 5'd0) ref_regs[ra] = rd;
      end else begin
        exp_d = ref_regs[ra];
      end
      vectors++;
      if ({a, d, l, e} !== {ra, exp_d, 1'b1, 1'b0} ||
          we_cnt !== ((op && ra != 5'd0) ? 1 : 0)) begin
        miscompares++;
        $display("FAIL random_op%0d: op=%0b rsp=%h we_cycles=%0d required %h", i, op,
                 {a, d, l, e}, we_cnt, {ra, exp_d, 2'b10});
      end
    end
  endtask

  task automatic test_reserved(input logic [1:0] op);
    bit ok; logic [4:0] a; logic [31:0] d; logic l, e;
    we_cnt = 0;
    issue(op, 5'd5, 32'hA5A5A5A5, ok);
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_err, rsp_data, rsp_last} !== {1'b1, 1'b1, 32'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL reserved_op%0d_turnaround: got %h required %h", op,
               {rsp_valid, rsp_err, rsp_data, rsp_last}, {2'b11, 32'd0, 1'b1});
    end
    get_rsp(1, a, d, l, e, ok);
    vectors++;
    if ({d, l, e} !== {32'd0, 1'b1, 1'b1} || we_cnt !== 0) begin
      miscompares++;
      $display("FAIL reserved_op%0d_rsp: got %h we_cycles=%0d required %h and 0", op,
               {d, l, e}, we_cnt, {32'd0, 2'b11});
    end
  endtask

  task automatic test_not_halted();
    logic [4:0] ra0, wa0;
    ra0 = rf_ra; wa0 = rf_wa; we_cnt = 0;
    @(negedge clk);
    core_halted = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 5'd7; cmd_wdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({cmd_ready, rsp_valid, busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL not_halted_cyc%0d: ready/valid/busy=%b required 000", i,
                 {cmd_ready, rsp_valid, busy});
      end
    end
    cmd_valid = 1'b0;
    vectors++;
    if (we_cnt !== 0 || rf_ra !== ra0 || rf_wa !== wa0) begin
      miscompares++;
      $display("FAIL not_halted_rf: we_cycles=%0d ra=%0d wa=%0d required 0 %0d %0d",
               we_cnt, rf_ra, rf_wa, ra0, wa0);
    end
    core_halted = 1'b1;
  endtask

`ifdef RF_DEBUG_DUMP_EN
  task automatic test_dump(input bit drop_halt);
    bit ok, holding;
    int beat, k, n;
    logic [37:0] held;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    beat = 0; k = 0; n = 0; holding = 0; held = '0;
    issue(2'b10, 5'd0, 32'd0, ok);
    while (ok && beat < 32 && n < 2000) begin
      @(negedge clk);
      n++;
      if (drop_halt && beat == 10) core_halted = 1'b0;
      if (rsp_valid && holding) begin
        vectors++;
        if ({rsp_addr, rsp_data, rsp_last} !== held) begin
          miscompares++;
          $display("FAIL dump_hold beat %0d: got %h required %h", beat,
                   {rsp_addr, rsp_data, rsp_last}, held);
        end
      end
      rsp_ready = pat[k % 4];
      k++;
      if (rsp_valid && rsp_ready) begin
        vectors++;
        if ({rsp_addr, rsp_data, rsp_last, rsp_err} !==
            {5'(beat), ref_regs[beat], beat == 31, 1'b0}) begin
          miscompares++;
          $display("FAIL dump_beat %0d: got %h required %h", beat,
                   {rsp_addr, rsp_data, rsp_last, rsp_err},
                   {5'(beat), ref_regs[beat], beat == 31, 1'b0});
        end
        beat++;
        holding = 0;
      end else if (rsp_valid) begin
        holding = 1;
        held = {rsp_addr, rsp_data, rsp_last};
      end
    end
    rsp_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (beat !== 32 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dump_complete: beats=%0d busy=%0b valid=%0b required 32 0 0",
               beat, busy, rsp_valid);
    end
    core_halted = 1'b1;
  endtask
`endif

  task automatic test_reset_mid();
    bit ok, seen; logic [4:0] a; logic [31:0] d; logic l, e;
    issue(2'b01, 5'd12, 32'hCAFE0012, ok);
    reset = 1'b1;
    ref_regs[12] = 32'hCAFE0012;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err,
         rf_ra, rf_wa, rf_wd, rf_we, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_in_wr: valid=%0b we=%0b busy=%0b wa=%0d required all 0",
               rsp_valid, rf_we, busy, rf_wa);
    end
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_rsp: rsp_valid seen=%0b required 0", seen);
    end
`ifdef RF_DEBUG_DUMP_EN
    issue(2'b10, 5'd0, 32'd0, ok);
    begin
      int n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err,
         rf_ra, rf_wa, rf_wd, rf_we, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_in_dump: valid=%0b busy=%0b ra=%0d required all 0",
               rsp_valid, busy, rf_ra);
    end
    reset = 1'b0;
`endif
    issue(2'b00, 5'd3, 32'd0, ok);
    get_rsp(0, a, d, l, e, ok);
    vectors++;
    if ({a, d, l, e} !== {5'd3, ref_regs[3], 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL read3_after_reset: got %h required %h", {a, d, l, e},
               {5'd3, ref_regs[3], 2'b10});
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i]   = 32'(i);
      ref_regs[i] = 32'(i);
    end
    reset = 1'b1; core_halted = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    test_reset();
`ifdef RF_DEBUG_DUMP_EN
    test_dump(0);
`endif
    test_write_read();
    test_x0_write();
    test_reserved(2'b11);
`ifndef RF_DEBUG_DUMP_EN
    test_reserved(2'b10);
`endif
    test_not_halted();
    test_random_ops();
`ifdef RF_DEBUG_DUMP_EN
    test_dump(1);
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_debug_port.md
Name: rf_debug_port

Overview:
- Debug-side master for the core register file: drives its read address, write address, write data and write-enable ports.
- Lets the PS/debug host read, write or dump all registers while the core is halted.
- Sits between the debug command channel and the regfile. The core-side regfile mux selects this block while core_halted=1.
- Commands arrive on a valid/ready channel. Results return on a valid/ready response channel.

Parameters:
NREGS, 32, number of architectural registers swept by a dump
AW, 5, register address width (clog2 NREGS)
DW, 32, register data width

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
core_halted  input  1  core is halted; gates command acceptance only
cmd_valid  input  1  command present
cmd_ready  output  1  block accepts command this cycle
cmd_op  input  2  00 read, 01 write, 10 dump, 11 reserved
cmd_addr  input  AW  register index for read/write
cmd_wdata  input  DW  write data
rsp_valid  output  1  response present
rsp_ready  input  1  host accepts response
rsp_addr  output  AW  register index of response
rsp_data  output  DW  read data, or echoed write data
rsp_last  output  1  final beat of a dump; 1 for single read/write
rsp_err  output  1  command rejected
rf_ra  output  AW  regfile read address (a1)
rf_rd  input  DW  regfile read data (rd1, combinational from rf_ra)
rf_wa  output  AW  regfile write address (a3)
rf_wd  output  DW  regfile write data (wd3)
rf_we  output  1  regfile write enable (we3)
busy  output  1  state != IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0; dump counter 0.
  - Reset mid-operation abandons the operation; no response is emitted.
  - rf_we is 0 in the cycle after the reset edge.
- cmd_ready = (state==IDLE) && core_halted && !reset.
- Acceptance = cmd_valid && cmd_ready at a posedge. cmd_addr, cmd_wdata and cmd_op are latched at that edge.
- States: IDLE, RD, WR, RSP, DUMP_RD, DUMP_RSP.
- Read (edge T accept):
  - IDLE->RD; rf_ra = addr during cycle T..T+1.
  - Edge T+1: capture rf_rd into rsp_data; rsp_valid=1, rsp_last=1; ->RSP.
- Write (edge T accept):
  - IDLE->WR; rf_we=1, rf_wa=addr, rf_wd=wdata for exactly one cycle. The regfile commits on the falling edge inside that cycle.
  - Edge T+1: rf_we=0; rsp_valid=1, rsp_data=wdata, rsp_last=1; ->RSP.
  - addr==0: rf_we stays 0 (x0 immutable). A normal response is still returned.
- RSP: rsp_valid and all rsp_* held stable until rsp_ready. At the handshake edge: rsp_valid=0, ->IDLE.
- Dump:
  - Accept: counter=0; ->DUMP_RD with rf_ra=counter.
  - Next edge: capture rf_rd; rsp_addr=counter; rsp_last=(counter==NREGS-1); ->DUMP_RSP.
  - On handshake: if last ->IDLE, else counter+1 ->DUMP_RD.
  - Minimum 2 cycles per beat. Exactly NREGS beats, addresses 0..NREGS-1 ascending. The x0 beat carries 0.
- Reserved op 11: one-cycle turnaround; rsp_valid=1, rsp_err=1, rsp_data=0, rsp_last=1; ->RSP.
- core_halted falling mid-operation: the operation, including a dump, runs to completion. Only new acceptance is blocked.
- rf_ra/rf_wa/rf_wd hold their last value when unused. rf_we is asserted only in WR.
- No combinational path from cmd_* or rsp_ready to any output.

Optional Feature:
RF_DEBUG_DUMP_EN:
- Defined: op 10 performs the dump sequence above.
- Undefined: DUMP states and the counter are not built. Op 10 is handled exactly like reserved op 11 (single rsp_err=1 beat).

Test Plan:
- Halted; write addr 9 data 0xDEADBEEF -> rf_we high exactly one cycle with rf_wa=9; response rsp_data=0xDEADBEEF, err=0, last=1; a following read of 9 returns 0xDEADBEEF.
- Write addr 0 data 0x12345678 -> rf_we never asserts; response still returned; read of 0 returns 0.
- Dump with rsp_ready toggling 1,0,0,1 -> 32 beats, addresses 0..31 in order, data unchanged while stalled, rsp_last only on beat 31. Regs 3 and 9 hold 3 and 9 after the power-up init. Requires RF_DEBUG_DUMP_EN.
- core_halted=0 with cmd_valid=1 -> cmd_ready=0, no rf activity. Drop halted mid-dump -> all 32 beats still delivered.
- op 11 at addr 5 -> single beat rsp_err=1, rsp_data=0, rf_we=0. Repeat op 10 with RF_DEBUG_DUMP_EN undefined -> identical result.
- Assert reset during WR and during DUMP_RSP -> next cycle all outputs 0, busy=0; a fresh read of addr 3 succeeds.
